blue_ctrl: RTL and testbench
============================

BLUE_CTRL -- requirements
Module: blue_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1666667, clk cycles per motion tick (60 Hz at 100 MHz).
REQ-002 SHALL have parameter RUN_STEP, default 2, horizontal pixels moved per tick.
REQ-003 SHALL have parameter JUMP_V0, default 12, initial upward speed in pixels/tick.
REQ-004 SHALL have parameter GRAVITY, default 1, speed decrement per tick.
REQ-005 SHALL have parameter X_INIT, default 100, and GROUND_Y, default 400, giving the reset position and the standing sprite-top row.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk  input  1  system clock.
REQ-008 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-009 SHALL have ports key_left, key_right and key_jump  input  1 each  levels, synchronous to clk.
REQ-010 SHALL have ports hcnt and vcnt  input  10 each  current VGA pixel column and row.
REQ-011 SHALL have port blue_state  output  3  bits[2:1] 00 stand, 01 run, 10 jump; bit0 facing, 1 right, 0 left.
REQ-012 SHALL have port blue  output  12  sprite ROM address, row*47+col.
REQ-013 SHALL have port blue_hit  output  1  current pixel lies inside the sprite.
REQ-014 SHALL have ports pos_x and pos_y  output  10 each  sprite top-left corner.

Function
REQ-015 SHALL generate a one-cycle tick when a 32-bit divider reaches TICK_DIV-1, then wrap the divider to 0.
REQ-016 SHALL update the state machine, position and speed only on tick cycles, and hold them otherwise.
REQ-017 SHALL use the states STAND, RUN and JUMP.
REQ-018 On a tick in STAND or RUN with key_jump=1, SHALL enter JUMP and set vy=JUMP_V0.
REQ-019 On a tick in STAND or RUN with key_jump=0 and exactly one of key_left/key_right set, SHALL enter RUN, set facing toward the key, and move x by RUN_STEP in that direction.
REQ-020 On a tick in STAND or RUN with key_jump=0 and both or neither direction key set, SHALL enter STAND with facing and x unchanged.
REQ-021 SHALL clamp x to the range 0..593 (640-47); a clamped move leaves the state as RUN.
REQ-022 On a tick in JUMP, SHALL apply the REQ-019/020 horizontal rules without a state change, ignore key_jump, and apply y_next=y-vy then vy_next=vy-GRAVITY using signed 11-bit arithmetic.
REQ-023 When y_next>=GROUND_Y, SHALL set y=GROUND_Y and vy=0, and SHALL enter RUN if exactly one direction key is set, else STAND.
REQ-024 When y_next<0, SHALL clamp y to 0 while vy continues to decrease.
REQ-025 SHALL set blue_hit, registered with 1-cycle latency, to 1 when pos_x<=hcnt<pos_x+47 and pos_y<=vcnt<pos_y+47.
REQ-026 SHALL set blue, registered with 1-cycle latency, to (vcnt-pos_y)*47+(hcnt-pos_x) when blue_hit is true, else 0; the maximum value is 2208.
REQ-027 SHALL drive blue_state, pos_x and pos_y directly from registers.

Reset
REQ-028 While rstn=0, SHALL hold: state STAND, facing right (blue_state=3'b001), pos_x=X_INIT, pos_y=GROUND_Y, vy=0, divider=0, blue=0, blue_hit=0.
REQ-029 Reset mid-jump SHALL abort the jump immediately; the first tick after release is TICK_DIV cycles later.

Structure
REQ-030 Package blue_pkg SHALL hold the state encodings, the sprite size 47, the screen size 640x480, and the blue_state field positions.
REQ-031 Divider SHALL be the sub-module tick_gen (clk, rstn, parameter DIV, output tick).

Verification (TICK_DIV=4)
REQ-032 Reset, then key_right=1 for 3 ticks -> blue_state=011, pos_x=106.
REQ-033 Key_left held from pos_x=1 -> pos_x=0 after 1 tick and stays 0, blue_state=010.
REQ-034 Tap key_jump for 1 tick -> blue_state=101, pos_y follows 388, 377, 367...; after 25 ticks pos_y=400 and blue_state=001.
REQ-035 Both direction keys held from STAND, facing left -> blue_state=000 and pos_x constant.
REQ-036 pos=(100,400), hcnt=146, vcnt=446 -> one cycle later blue_hit=1, blue=2208; hcnt=147 -> blue_hit=0, blue=0.
REQ-037 Assert rstn=0 mid-jump at pos_y=350 -> pos_y=400, blue_state=001 immediately, with no tick for 4 cycles after release.

Source files
------------

// File: rtl/blue_pkg.sv
// rtl/blue_pkg.sv - shared encodings and geometry for the blue sprite controller
package blue_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_STAND = 2'b00;
  localparam state_t ST_RUN   = 2'b01;
  localparam state_t ST_JUMP  = 2'b10;

  localparam int SPRITE_SIZE = 47;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int X_MAX       = SCREEN_W - SPRITE_SIZE;

  localparam int BS_FACE_BIT = 0;
  localparam int BS_STATE_LO = 1;
  localparam int BS_STATE_HI = 2;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle motion tick
module tick_gen #(
  parameter int DIV = 1666667
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  logic [31:0] cnt;

  assign tick = (cnt == 32'(DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/blue_ctrl.sv
// rtl/blue_ctrl.sv - stand/run/jump motion of the blue sprite plus pixel hit and ROM address
module blue_ctrl
  import blue_pkg::*;
#(
  parameter int TICK_DIV = 1666667,
  parameter int RUN_STEP = 2,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1,
  parameter int X_INIT   = 100,
  parameter int GROUND_Y = 400
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_jump,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  output logic [2:0]  blue_state,
  output logic [11:0] blue,
  output logic        blue_hit,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y
);

  localparam logic signed [11:0] STEP_S   = 12'(RUN_STEP);
  localparam logic signed [11:0] XMAX_S   = 12'(X_MAX);
  localparam logic signed [10:0] V0_S     = 11'(JUMP_V0);
  localparam logic signed [10:0] GRAV_S   = 11'(GRAVITY);
  localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);

  logic tick;
  tick_gen #(.DIV(TICK_DIV)) u_tick (.clk(clk), .rstn(rstn), .tick(tick));

  state_t            state_q, state_d;
  logic              facing_q, facing_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic signed [10:0] vy_q, vy_d;

  logic              one_key;
  logic signed [11:0] x_ext, x_right, x_left;
  logic [9:0]        x_h;
  logic signed [10:0] y_calc, vy_calc;

  assign one_key = key_left ^ key_right;
  assign x_ext   = $signed({2'b00, x_q});
  assign x_right = x_ext + STEP_S;
  assign x_left  = x_ext - STEP_S;
  assign y_calc  = $signed({1'b0, y_q}) - vy_q;
  assign vy_calc = vy_q - GRAV_S;

  // Horizontal result for a single held direction key, clamped to the visible span
  always_comb begin
    x_h = x_q;
    if (key_right) x_h = (x_right > XMAX_S) ? 10'(X_MAX) : x_right[9:0];
    else           x_h = (x_left < 12'sd0) ? 10'd0 : x_left[9:0];
  end

  always_comb begin
    state_d  = state_q;
    facing_d = facing_q;
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;
    case (state_q)
      ST_STAND, ST_RUN: begin
        if (key_jump) begin
          state_d = ST_JUMP;
          vy_d    = V0_S;
        end else begin
          state_d = one_key ? ST_RUN : ST_STAND;
          if (one_key) begin
            facing_d = key_right;
            x_d      = x_h;
          end
        end
      end
      ST_JUMP: begin
        if (one_key) begin
          facing_d = key_right;
          x_d      = x_h;
        end
        if (y_calc >= GROUND_S) begin
          y_d     = 10'(GROUND_Y);
          vy_d    = '0;
          state_d = one_key ? ST_RUN : ST_STAND;
        end else begin
          y_d  = (y_calc < 11'sd0) ? 10'd0 : y_calc[9:0];
          vy_d = vy_calc;
        end
      end
      default: state_d = ST_STAND;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_STAND;
      facing_q <= 1'b1;
      x_q      <= 10'(X_INIT);
      y_q      <= 10'(GROUND_Y);
      vy_q     <= '0;
    end else if (tick) begin
      state_q  <= state_d;
      facing_q <= facing_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
    end
  end

  logic [10:0] x_end, y_end;
  logic [9:0]  dx, dy;
  logic        hit_c;
  logic [11:0] addr_c;

  assign x_end  = {1'b0, x_q} + 11'(SPRITE_SIZE);
  assign y_end  = {1'b0, y_q} + 11'(SPRITE_SIZE);
  assign hit_c  = (hcnt >= x_q) && ({1'b0, hcnt} < x_end) &&
                  (vcnt >= y_q) && ({1'b0, vcnt} < y_end);
  assign dx     = hcnt - x_q;
  assign dy     = vcnt - y_q;
  assign addr_c = 12'(dy) * 12'(SPRITE_SIZE) + 12'(dx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blue_hit <= 1'b0;
      blue     <= '0;
    end else begin
      blue_hit <= hit_c;
      blue     <= hit_c ? addr_c : 12'd0;
    end
  end

  assign blue_state[BS_STATE_HI:BS_STATE_LO] = state_q;
  assign blue_state[BS_FACE_BIT]             = facing_q;
  assign pos_x = x_q;
  assign pos_y = y_q;

endmodule

// File: tb/tb_blue_ctrl.sv
// tb/tb_blue_ctrl.sv - self-checking bench for blue_ctrl with a behavioural motion model
module tb_blue_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
  logic [9:0]  hcnt = '0, vcnt = '0;
  logic [2:0]  blue_state;
  logic [11:0] blue;
  logic        blue_hit;
  logic [9:0]  pos_x, pos_y;

  blue_ctrl #(.TICK_DIV(DIV)) dut (
    .clk(clk), .rstn(rstn),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .hcnt(hcnt), .vcnt(vcnt),
    .blue_state(blue_state), .blue(blue), .blue_hit(blue_hit),
    .pos_x(pos_x), .pos_y(pos_y)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 stand, 1 run, 2 jump; all plain integers
  int m_mode, m_face, m_x, m_y, m_vy;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hit;
    logic [11:0] addr;
  } pix_vec_t;

  pix_vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_face = 1; m_x = 100; m_y = 400; m_vy = 0;
  endtask

  task automatic model_tick(input int l, input int r, input int j);
    int single, nx, nf, yn;
    single = (l != r);
    nx = m_x; nf = m_face;
    if (single) begin
      nf = r;
      nx = clampi(m_x + (r ? 2 : -2), 0, 593);
    end
    if (m_mode != 2) begin
      if (j) begin
        m_mode = 2; m_vy = 12;
      end else begin
        m_mode = single ? 1 : 0; m_x = nx; m_face = nf;
      end
    end else begin
      m_x = nx; m_face = nf;
      yn = m_y - m_vy;
      if (yn >= 400) begin
        m_y = 400; m_vy = 0; m_mode = single ? 1 : 0;
      end else begin
        m_y = (yn < 0) ? 0 : yn;
        m_vy = m_vy - 1;
      end
    end
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".state"}, int'(blue_state), m_mode * 2 + m_face);
    chk({nm, ".x"}, int'(pos_x), m_x);
    chk({nm, ".y"}, int'(pos_y), m_y);
  endtask

  // Entered and left at #1 after a rising edge, one full divider period per call
  task automatic do_tick(input int l, input int r, input int j, input string nm);
    key_left = 1'(l); key_right = 1'(r); key_jump = 1'(j);
    repeat (DIV) @(posedge clk);
    #1;
    model_tick(l, r, j);
    check_model(nm);
  endtask

  task automatic do_reset(input string nm);
    #2 rstn = 1'b0;
    key_left = 0; key_right = 0; key_jump = 0;
    #1;
    chk({nm, ".rst_state"}, int'(blue_state), 1);
    chk({nm, ".rst_x"}, int'(pos_x), 100);
    chk({nm, ".rst_y"}, int'(pos_y), 400);
    chk({nm, ".rst_hit"}, int'(blue_hit), 0);
    chk({nm, ".rst_blue"}, int'(blue), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int jump_y[5];
    int px, py, h, v, eh, ea;
    jump_y[0] = 388; jump_y[1] = 377; jump_y[2] = 367; jump_y[3] = 358; jump_y[4] = 350;

    vecs[0] = '{10'd146, 10'd446, 1'b1, 12'd2208};
    vecs[1] = '{10'd147, 10'd446, 1'b0, 12'd0};
    vecs[2] = '{10'd100, 10'd400, 1'b1, 12'd0};
    vecs[3] = '{10'd99,  10'd400, 1'b0, 12'd0};
    vecs[4] = '{10'd120, 10'd410, 1'b1, 12'd490};
    vecs[5] = '{10'd100, 10'd399, 1'b0, 12'd0};
    vecs[6] = '{10'd145, 10'd447, 1'b0, 12'd0};
    vecs[7] = '{10'd146, 10'd400, 1'b1, 12'd46};

    @(posedge clk); #1;
    do_reset("init");

    for (int i = 0; i < 3; i++) do_tick(0, 1, 0, "run_right");
    chk("run_right.final_state", int'(blue_state), 3);
    chk("run_right.final_x", int'(pos_x), 106);

    do_tick(1, 0, 0, "face_left");
    for (int i = 0; i < 3; i++) do_tick(1, 1, 0, "both_keys");
    chk("both_keys.state", int'(blue_state), 0);
    chk("both_keys.x", int'(pos_x), 104);

    do_reset("jump");
    do_tick(0, 0, 1, "jump_tap");
    chk("jump_tap.state", int'(blue_state), 5);
    for (int i = 0; i < 25; i++) begin
      do_tick(0, 0, 0, "jump_arc");
      if (i < 3) chk("jump_arc.y_table", int'(pos_y), jump_y[i]);
    end
    chk("jump_land.y", int'(pos_y), 400);
    chk("jump_land.state", int'(blue_state), 1);

    for (int i = 0; i < 53; i++) do_tick(1, 0, 0, "left_clamp");
    chk("left_clamp.x", int'(pos_x), 0);
    chk("left_clamp.state", int'(blue_state), 2);
    for (int i = 0; i < 300; i++) do_tick(0, 1, 0, "right_clamp");
    chk("right_clamp.x", int'(pos_x), 593);
    chk("right_clamp.state", int'(blue_state), 3);

    do_reset("mid_jump");
    do_tick(0, 0, 1, "mid_jump.enter");
    for (int i = 0; i < 5; i++) do_tick(0, 0, 0, "mid_jump.rise");
    chk("mid_jump.y_before_reset", int'(pos_y), jump_y[4]);
    do_reset("mid_jump.abort");
    key_right = 1'b1;
    for (int k = 1; k < DIV; k++) begin
      @(posedge clk); #1;
      chk("post_reset.no_tick_x", int'(pos_x), 100);
    end
    @(posedge clk); #1;
    model_tick(0, 1, 0);
    chk("post_reset.first_tick_x", int'(pos_x), 102);
    check_model("post_reset");

    do_reset("random");
    for (int i = 0; i < 400; i++)
      do_tick(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 9) == 0), "random");
    for (int i = 0; i < 30; i++) do_tick(0, 0, 0, "settle");

    px = m_x; py = m_y;
    for (int i = 0; i < 40; i++) begin
      h = clampi(px - 3 + int'($urandom_range(0, 52)), 0, 639);
      v = clampi(py - 3 + int'($urandom_range(0, 52)), 0, 479);
      hcnt = 10'(h); vcnt = 10'(v);
      @(posedge clk); #1;
      eh = (h >= px && h < px + 47 && v >= py && v < py + 47) ? 1 : 0;
      ea = eh ? (v - py) * 47 + (h - px) : 0;
      chk("probe.hit", int'(blue_hit), eh);
      chk("probe.addr", int'(blue), ea);
    end

    do_reset("pixel_table");
    for (int i = 0; i < 8; i++) begin
      hcnt = vecs[i].h; vcnt = vecs[i].v;
      @(posedge clk); #1;
      chk($sformatf("pix[%0d].hit", i), int'(blue_hit), int'(vecs[i].hit));
      chk($sformatf("pix[%0d].addr", i), int'(blue), int'(vecs[i].addr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
